grid_scheduler: RTL
===================

# grid_scheduler

Frame-level scheduler and owner arbiter for the shared 40x30 level grid RAM. On each frame tick it runs the enabled grid clients in a fixed order: player updater, then enemy updater, then renderer. It issues each client a one-cycle `start`, gives that client sole access to the grid port, and waits for the client's `done` before moving on. It sits between the top-level frame timer, the three client FSMs and the single grid RAM port.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 24'd2000000: max cycles a client may hold the grid before it is aborted. Used only with `GRID_SCHED_TIMEOUT_EN`.

Ports:
- `clock`  in  1  single system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `frame_tick`  in  1  one-cycle pulse that requests a new frame pass.
- `client_en`  in  3  per-client enable. Bit 0 = player, bit 1 = enemy, bit 2 = renderer.
- `frame_done`  out  1  one-cycle pulse when the pass completes.
- `overrun`  out  1  sticky. Set when `frame_tick` arrives while a pass is in progress.
- `timeout_flags`  out  3  sticky, one bit per client. Set when that client is aborted.
- `cN_start`  out  1  (N=0..2) one-cycle start pulse to client N.
- `cN_done`  in  1  done pulse from client N.
- `cN_grid_x`  in  6, `cN_grid_y`  in  5, `cN_grid_write`  in  1, `cN_grid_in`  in  3: client N's grid request.
- `grid_x`  out  6, `grid_y`  out  5, `grid_write`  out  1, `grid_in`  out  3: to the grid RAM.
- `grid_out`  in  3: RAM read data. Not routed through the block; it is fanned out to all clients at top level.

## Operation
- State register values: IDLE, START, RUN, NEXT, FINISH. Owner register: 2 bits, values 0..2.
- IDLE:
  - On `frame_tick`, latch `client_en` into `en_q`.
  - If `en_q` is nonzero, set owner to the lowest set bit and go to START.
  - Otherwise go to FINISH.
- START: assert `c[owner]_start`, then go to RUN.
- RUN:
  - On `c[owner]_done`, go to NEXT.
  - `done` from non-owners is ignored in every state.
- NEXT:
  - If a higher-numbered bit is set in `en_q`, set owner to it and go to START.
  - Otherwise go to FINISH.
- FINISH: assert `frame_done`, then go to IDLE.
- Grid mux:
  - Combinational. In START, RUN and NEXT, the grid outputs equal the owner's inputs. This keeps the client's address-to-`grid_out` timing identical to a direct connection.
  - In IDLE and FINISH, `grid_x`, `grid_y`, `grid_in` and `grid_write` are all 0.
- `client_en` changes during a pass have no effect until the next `frame_tick` is accepted in IDLE.
- `frame_tick` in any state other than IDLE sets `overrun` and is otherwise dropped. It is not queued.
- `overrun` and `timeout_flags` are cleared only by `reset`.

## Timing
- Reset values: state IDLE, owner 0, all `cN_start` 0, `frame_done` 0, `overrun` 0, `timeout_flags` 0, grid outputs 0.
- `frame_tick` seen at edge k moves the FSM to START at k+1, so the first `start` is high for cycle k+1.
- A client `done` seen at edge d gives the next client's `start` at d+2 (via NEXT). The last client's `done` at edge d gives `frame_done` at d+2.
- With all clients disabled, `frame_tick` at edge k gives `frame_done` high for cycle k+1.
- Pass length = 1 + Σ(enabled clients' run cycles + 2) cycles.
- Reset mid-pass: the next edge returns everything to reset values and no `start` or `frame_done` is emitted. Clients share the same `reset`.
- `cN_start` and `frame_done` are combinational decodes of registered state and owner.

## Configuration
- `GRID_SCHED_TIMEOUT_EN` defined:
  - A 24-bit counter is cleared in START and increments each RUN cycle.
  - If it reaches `TIMEOUT_CYCLES - 1` without the owner's `done`, set `timeout_flags[owner]` and go to NEXT.
  - A `done` in that same cycle takes priority, and no flag is set.
- Not defined: no counter; RUN waits indefinitely; `timeout_flags` is tied to 0.

## Test plan
- `client_en`=3'b111, `frame_tick` at cycle 10; each client pulses `done` 5 cycles after its `start`.
  - Required: `start` pulses at cycles 11, 18 and 25 in order c0, c1, c2; `frame_done` at cycle 32.
- `client_en`=3'b101.
  - Required: c1 never receives `start`; c2 `start` follows c0's `done` by 2 cycles.
- During c1 ownership, drive c0 and c2 with `grid_write`=1 and x=7, and c1 with x=12, y=3, `grid_in`=4.
  - Required: RAM sees x=12, y=3, write=1, in=4 only.
  - Required: in IDLE, RAM sees `grid_write`=0.
- `frame_tick` mid-pass; also `client_en`=0.
  - Required: `overrun`=1 and the pass is unaffected.
  - Required: with `client_en`=0, `frame_done` comes 1 cycle after the tick.
- Assert `reset` while c1 is in RUN.
  - Required: next cycle all outputs at reset values; a following `frame_tick` restarts from c0.
- With `GRID_SCHED_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, c1 never asserts `done`.
  - Required: `timeout_flags`=3'b010, c2 still runs, and `frame_done` is asserted.

Source files
------------

// File: rtl/grid_scheduler.sv
// grid_scheduler: per-frame sequencer and grid RAM owner mux for player, enemy and renderer clients.
// Optional hung-client abort enabled by defining GRID_SCHED_TIMEOUT_EN.
module grid_scheduler #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [2:0] client_en,
  output logic       frame_done,
  output logic       overrun,
  output logic [2:0] timeout_flags,
  output logic       c0_start,
  input  logic       c0_done,
  input  logic [5:0] c0_grid_x,
  input  logic [4:0] c0_grid_y,
  input  logic       c0_grid_write,
  input  logic [2:0] c0_grid_in,
  output logic       c1_start,
  input  logic       c1_done,
  input  logic [5:0] c1_grid_x,
  input  logic [4:0] c1_grid_y,
  input  logic       c1_grid_write,
  input  logic [2:0] c1_grid_in,
  output logic       c2_start,
  input  logic       c2_done,
  input  logic [5:0] c2_grid_x,
  input  logic [4:0] c2_grid_y,
  input  logic       c2_grid_write,
  input  logic [2:0] c2_grid_in,
  output logic [5:0] grid_x,
  output logic [4:0] grid_y,
  output logic       grid_write,
  output logic [2:0] grid_in,
  input  logic [2:0] grid_out
);
  typedef enum logic [2:0] {IDLE, START, RUN, NEXT, FINISH} state_t;
  state_t     r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt, w_first, w_higher;
  logic [2:0] r_en_q, w_done_v;
  logic       r_overrun, w_owner_done, w_has_higher, w_expire, w_busy;
  assign w_done_v     = {c2_done, c1_done, c0_done};
  assign w_owner_done = w_done_v[r_owner];
  assign w_first      = client_en[0] ? 2'd0 : client_en[1] ? 2'd1 : 2'd2;
  assign w_has_higher = (r_owner == 2'd0 && |r_en_q[2:1]) || (r_owner == 2'd1 && r_en_q[2]);
  assign w_higher     = (r_owner == 2'd0 && r_en_q[1]) ? 2'd1 : 2'd2;
  assign w_busy       = r_state == START || r_state == RUN || r_state == NEXT;
  assign overrun      = r_overrun;
`ifdef GRID_SCHED_TIMEOUT_EN
  logic [23:0] r_cnt;
  logic [2:0]  r_to;
  logic        w_unused;
  assign w_unused      = ^grid_out;
  assign w_expire      = r_cnt == TIMEOUT_CYCLES - 24'd1;
  assign timeout_flags = r_to;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= '0;
      r_to  <= '0;
    end else begin
      r_cnt <= r_state == START ? 24'd0 : r_state == RUN ? r_cnt + 24'd1 : r_cnt;
      if (r_state == RUN && !w_owner_done && w_expire) r_to <= r_to | (3'b001 << r_owner);
    end
  end
`else
  logic w_unused;
  assign w_unused      = ^{grid_out, TIMEOUT_CYCLES};
  assign w_expire      = 1'b0;
  assign timeout_flags = 3'b000;
`endif
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 2'd0;
      r_en_q    <= 3'b000;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      if (r_state == IDLE && frame_tick) r_en_q <= client_en;
      if (r_state != IDLE && frame_tick) r_overrun <= 1'b1;
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      IDLE: if (frame_tick) begin
        w_state_nxt = |client_en ? START : FINISH;
        w_owner_nxt = |client_en ? w_first : r_owner;
      end
      START:  w_state_nxt = RUN;
      RUN:    w_state_nxt = (w_owner_done || w_expire) ? NEXT : RUN;
      NEXT: begin
        w_state_nxt = w_has_higher ? START : FINISH;
        w_owner_nxt = w_has_higher ? w_higher : r_owner;
      end
      FINISH: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // Mux is purely combinational so a client sees the same address-to-grid_out path as a direct wire.
  always_comb begin
    c0_start   = r_state == START && r_owner == 2'd0;
    c1_start   = r_state == START && r_owner == 2'd1;
    c2_start   = r_state == START && r_owner == 2'd2;
    frame_done = r_state == FINISH;
    grid_x     = !w_busy ? 6'd0 : r_owner == 2'd0 ? c0_grid_x : r_owner == 2'd1 ? c1_grid_x : c2_grid_x;
    grid_y     = !w_busy ? 5'd0 : r_owner == 2'd0 ? c0_grid_y : r_owner == 2'd1 ? c1_grid_y : c2_grid_y;
    grid_write = !w_busy ? 1'b0 : r_owner == 2'd0 ? c0_grid_write : r_owner == 2'd1 ? c1_grid_write : c2_grid_write;
    grid_in    = !w_busy ? 3'd0 : r_owner == 2'd0 ? c0_grid_in : r_owner == 2'd1 ? c1_grid_in : c2_grid_in;
  end
endmodule
